// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline_reg_chain elastic pipeline.
//   occ_width(stages) : width of an occupancy counter able to hold 0..2*stages
//   skid_state_t      : observable fill state of one skid stage, used by
//                       checker/coverage code rather than by the datapath
// Optional feature macro used by the importing files: PIPE_FLUSH_EN.
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Each stage holds at most two beats, so the count spans 0..2*stages.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/skid_buffer_stage.sv
// -----------------------------------------------------------------------------
// skid_buffer_stage
// One elastic valid/ready stage built from a main register and a skid
// register. Upstream ready comes straight from the skid-valid flop, so there
// is no combinational path from o_ready to i_ready.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   flush               synchronous discard of both entries (PIPE_FLUSH_EN only)
//   i_valid/i_ready/i_data   upstream handshake
//   o_valid/o_ready/o_data   downstream handshake
//
// Optional feature macro: PIPE_FLUSH_EN (adds the flush input).
// -----------------------------------------------------------------------------
module skid_buffer_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef PIPE_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  m_v_q, m_v_d;
    logic [DATA_WIDTH-1:0] m_d_q, m_d_d;
    logic                  s_v_q, s_v_d;
    logic [DATA_WIDTH-1:0] s_d_q, s_d_d;

    logic drain_s;
    logic accept_s;

    assign i_ready  = !s_v_q;
    assign o_valid  = m_v_q;
    assign o_data   = m_d_q;

    assign drain_s  = m_v_q && o_ready;
    // A full skid means upstream sees i_ready = 0, so no accept can coincide
    // with a skid-to-main move.
    assign accept_s = i_valid && !s_v_q;

    // Next-state selection for the main and skid entries.
    always_comb begin
        m_v_d = m_v_q;
        m_d_d = m_d_q;
        s_v_d = s_v_q;
        s_d_d = s_d_q;
`ifdef PIPE_FLUSH_EN
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else
`endif
        begin
            if (drain_s) begin
                if (s_v_q) begin
                    // Oldest waiting beat moves forward; skid frees up.
                    m_v_d = 1'b1;
                    m_d_d = s_d_q;
                    s_v_d = 1'b0;
                end else if (accept_s) begin
                    m_v_d = 1'b1;
                    m_d_d = i_data;
                end else begin
                    m_v_d = 1'b0;
                end
            end else if (accept_s) begin
                if (!m_v_q) begin
                    m_v_d = 1'b1;
                    m_d_d = i_data;
                end else begin
                    // Main is stalled: park the beat so upstream is not
                    // throttled by a same-cycle ready path.
                    s_v_d = 1'b1;
                    s_d_d = i_data;
                end
            end else begin
                m_v_d = m_v_q;
                s_v_d = s_v_q;
            end
        end
    end

    // Main and skid registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_v_q <= 1'b0;
            m_d_q <= {DATA_WIDTH{1'b0}};
            s_v_q <= 1'b0;
            s_d_q <= {DATA_WIDTH{1'b0}};
        end else begin
            m_v_q <= m_v_d;
            m_d_q <= m_d_d;
            s_v_q <= s_v_d;
            s_d_q <= s_d_d;
        end
    end

endmodule

// File: rtl/pipeline_reg_chain.sv
// -----------------------------------------------------------------------------
// pipeline_reg_chain
// A chain of STAGES skid-buffer stages giving full throughput, STAGES cycles
// of latency and a registered in_ready. Also keeps a registered count of the
// beats currently held (0..2*STAGES).
//
// Parameters:
//   DATA_WIDTH  payload width in bits (>=1)
//   STAGES      number of skid-buffer stages (>=1)
//
// Ports:
//   clk, reset_n                  rising-edge clock, async active-low reset
//   in_data/in_valid/in_ready     upstream handshake (in_ready from a flop)
//   out_data/out_valid/out_ready  downstream handshake
//   occupancy                     beats held in the chain
//   flush                         synchronous discard (PIPE_FLUSH_EN only)
//
// Optional feature macro: PIPE_FLUSH_EN (adds the flush input and its logic).
// -----------------------------------------------------------------------------
module pipeline_reg_chain
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
`ifdef PIPE_FLUSH_EN
    input  logic                             flush,
`endif
    output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

    localparam int OCC_W = occ_width(STAGES);

    // Index k is the handshake between stage k-1 and stage k; index 0 is the
    // chain input and index STAGES is the chain output.
    logic [STAGES:0]       vld_s;
    logic [STAGES:0]       rdy_s;
    logic [DATA_WIDTH-1:0] dat_s [0:STAGES];

    logic             in_xfer_s;
    logic             out_xfer_s;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign vld_s[0]      = in_valid;
    assign dat_s[0]      = in_data;
    assign in_ready      = rdy_s[0];
    assign out_valid     = vld_s[STAGES];
    assign out_data      = dat_s[STAGES];
    assign rdy_s[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        skid_buffer_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
`ifdef PIPE_FLUSH_EN
            .flush   (flush),
`endif
            .i_valid (vld_s[k]),
            .i_ready (rdy_s[k]),
            .i_data  (dat_s[k]),
            .o_valid (vld_s[k+1]),
            .o_ready (rdy_s[k+1]),
            .o_data  (dat_s[k+1])
        );
    end

    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid && out_ready;

    // Occupancy up/down step; simultaneous in and out leave it unchanged.
    always_comb begin
        occ_d = occ_q;
`ifdef PIPE_FLUSH_EN
        if (flush) begin
            occ_d = {OCC_W{1'b0}};
        end else
`endif
        begin
            case ({in_xfer_s, out_xfer_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Occupancy register; bounded by the stage capacity, so no saturation logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= {OCC_W{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
